// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// Module   : led_fader
// Purpose  : Turns the hard on/off level from the blinky ticker into a
//            linear PWM brightness ramp for the board LED. Each change of the
//            target level starts a fade-in or fade-out; a change during a
//            fade reverses it from the current brightness.
// Ports    : sys_clk   - system clock, rising edge
//            sys_reset - asynchronous active-low reset (0 = reset)
//            blink_in  - target level, asynchronous, synchronised here
//            led       - registered PWM drive to the LED pin
//            duty      - current brightness (PWM_BITS wide)
//            busy      - high while a fade is in progress
// Revision : 1.0 - initial release
// ============================================================================
module led_fader #(
  parameter int PWM_BITS       = 8,
  parameter int STEP_DIV       = 64,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  input  logic                blink_in,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0]       STEP_LAST = TW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } state_e;

  logic                sync1_q;
  logic                tgt_q;
  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                busy_q, busy_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                led_q;
  logic                lit;

  // Next-state, duty step and step-timer logic.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    timer_d = timer_q;

    if (state_q == ST_RISE || state_q == ST_FALL) begin
      if (timer_q == STEP_LAST) begin
        timer_d = '0;
        // Saturating step in the current fade direction.
        if (state_q == ST_RISE && duty_q != DUTY_MAX) duty_d = duty_q + 1'b1;
        if (state_q == ST_FALL && duty_q != '0)       duty_d = duty_q - 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    // End-of-fade tests use duty_d so ON/OFF is entered on the same edge the
    // end value lands; a reversal wins over completing the current fade.
    case (state_q)
      ST_OFF:  if (tgt_q) state_d = ST_RISE;
      ST_RISE: begin
        if (!tgt_q)                 state_d = ST_FALL;
        else if (duty_d == DUTY_MAX) state_d = ST_ON;
      end
      ST_ON:   if (!tgt_q) state_d = ST_FALL;
      ST_FALL: begin
        if (tgt_q)              state_d = ST_RISE;
        else if (duty_d == '0)  state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    // Every state change restarts the step interval.
    if (state_d != state_q) timer_d = '0;

    busy_d = (state_d == ST_RISE) || (state_d == ST_FALL);
  end

  // Full brightness is forced solid so ON has no dark slot at pwm_cnt=max.
  assign lit = (duty_q == DUTY_MAX) || (pwm_cnt_q < duty_q);

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      sync1_q   <= 1'b0;
      tgt_q     <= 1'b0;
      state_q   <= ST_OFF;
      duty_q    <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      pwm_cnt_q <= '0;
      led_q     <= LED_ACTIVE_LOW;
    end else begin
      sync1_q   <= blink_in;
      tgt_q     <= sync1_q;
      state_q   <= state_d;
      duty_q    <= duty_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      led_q     <= lit ^ LED_ACTIVE_LOW;
    end
  end

  assign led  = led_q;
  assign duty = duty_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream stage for the blinky ticker: consumes its hard-toggling `led` level and drives the physical LED with a PWM brightness ramp.
- Each change of the input level produces a linear fade-in or fade-out instead of an abrupt step.
- Sits between the blinky instance and the board LED pin in the top level.

Parameters:
- PWM_BITS, 8: width of the duty and PWM counters. PWM period = 2^PWM_BITS clocks. Legal values ≥ 2.
- STEP_DIV, 64: clocks per ±1 duty step. Full fade = (2^PWM_BITS−1)·STEP_DIV clocks. Legal values ≥ 1.
- LED_ACTIVE_LOW, 0: 1 inverts the `led` output for active-low board LEDs.

Ports:
- sys_clk  input  1  system clock; all state changes on its rising edge.
- sys_reset  input  1  asynchronous, active-low reset (0 = reset).
- blink_in  input  1  target level from the upstream blinky; asynchronous to this block's logic, so it is synchronised.
- led  output  1  registered PWM drive to the LED pin.
- duty  output  PWM_BITS  current brightness.
- busy  output  1  high while a fade is in progress.

Behaviour:
- Reset (sys_reset=0):
  - Takes effect immediately, with no clock edge needed.
  - sync regs=0, state=OFF, duty=0, step timer=0, pwm_cnt=0, busy=0.
  - led=LED_ACTIVE_LOW (lit state off).
- Synchroniser: 2-FF on blink_in; tgt = second flop. A blink_in change is visible in tgt after 2 edges.
- States: OFF, RISE, ON, FALL. busy=1 exactly in RISE/FALL, registered with the state.
- State transitions, evaluated every edge:
  - OFF & tgt=1 → RISE
  - ON & tgt=0 → FALL
  - RISE & tgt=0 → FALL (reversal; duty is kept)
  - FALL & tgt=1 → RISE (reversal; duty is kept)
  - RISE & duty reaches all-ones → ON
  - FALL & duty reaches 0 → OFF
- Latency: blink_in change → busy rises on the 3rd rising edge.
- Step timer:
  - Cleared on every state change.
  - Counts 0..STEP_DIV−1 while in RISE/FALL.
  - At STEP_DIV−1 it clears and duty steps ±1.
  - First step lands STEP_DIV clocks after entering RISE/FALL.
  - STEP_DIV=1 steps every clock.
- Duty arithmetic:
  - Unsigned, saturating: never increments past all-ones, never decrements below 0.
  - The transition to ON/OFF is taken on the same edge duty reaches its end value.
- PWM:
  - pwm_cnt is free-running and wraps all-ones→0. It is not reset by fades.
  - lit = (duty==all-ones) ? 1 : (pwm_cnt < duty).
  - led is registered: led <= lit XOR LED_ACTIVE_LOW, so there is a 1-clock delay from pwm_cnt/duty.
  - duty=0 gives lit=0 constantly. duty=all-ones gives lit=1 constantly, so ON has no dark slot.
- Simultaneous events: a reversal on the same edge as a duty step applies the step, then switches state with the timer cleared.
- Reset mid-fade: duty returns to 0 immediately. After release, fading restarts from 0 according to tgt.

Test Plan:
Benches use PWM_BITS=4, STEP_DIV=2 unless stated.

1. Reset: sys_reset=0 with blink_in=1 for 5 clocks → led=0, duty=0, busy=0 throughout. Release → busy=1 on 3rd edge; duty=15 and busy=0 exactly 30 clocks after busy rose; led stays 1 while in ON.
2. Fade-out: steady ON, blink_in→0 → busy rises on 3rd edge; duty decrements 15→0 by 1 every 2 clocks; state OFF and busy=0 at duty=0; led stays 0 afterwards.
3. PWM duty: STEP_DIV=1000, blink_in=1, freeze the check while duty=4 → within each 16-clock period led=1 for exactly 4 consecutive clocks (pwm_cnt 0..3, plus 1-clock register delay).
4. Reversal: rising, blink_in→0 when duty=7 → duty continues 7,6,…,0 with no jump; first decrement 2 clocks after entering FALL; ends OFF.
5. Async reset mid-fade: drive sys_reset=0 between clock edges at duty=9 → duty=0, led=0, busy=0 before the next edge. Release with blink_in=1 → fade restarts from 0.
6. LED_ACTIVE_LOW=1: repeat scenario 1 → led=1 during reset and in OFF, led=0 throughout ON.
